solver_drain: RTL and testbench

- Read-side sequencer for the per-solver 1024x8 result RAMs filled by the multi-solver array.
- After the solvers finish, it walks every solver bank in order: solver 0 addr 0..DEPTH-1, then solver 1, and so on.
- It drives the array's rd_solver_id/rd_addr read port and absorbs the 1-cycle RAM read latency.
- It emits each pixel on a valid/ready stream to the downstream framebuffer writer, tagged with solver id and address.

---
 rtl/solver_drain_pkg.sv | 26 ++
 rtl/drain_fifo2.sv | 56 +++++
 rtl/solver_drain.sv | 145 ++++++++++++++
 tb/tb_solver_drain.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/solver_drain_pkg.sv
// Shared definitions for the solver result-RAM drain sequencer.
package solver_drain_pkg;

  localparam int SOLVER_ID_W    = 6;
  localparam int RAM_ADDR_W     = 10;
  localparam int PIXEL_W        = 8;
  localparam int RAM_RD_LATENCY = 1;

  // Reads in flight plus buffered words: one slot per cycle of RAM latency
  // plus one to keep streaming at a word per cycle.
  localparam int CREDIT_LIMIT = RAM_RD_LATENCY + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    FLUSH = 2'd2
  } drain_state_t;

  // One pixel together with the bank/address it was read from.
  typedef struct packed {
    logic [SOLVER_ID_W-1:0] solver_id;
    logic [RAM_ADDR_W-1:0]  addr;
    logic [PIXEL_W-1:0]     data;
  } drain_word_t;

endpackage

// File: rtl/drain_fifo2.sv
// Two-entry FIFO of tagged pixels between the RAM read port and the stream.
module drain_fifo2
  import solver_drain_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        push,
  input  logic        pop,
  input  drain_word_t wdata,
  output drain_word_t rdata,
  output logic [1:0]  count,
  output logic        full,
  output logic        empty
);

  drain_word_t mem [2];
  logic        wr_ptr;
  logic        rd_ptr;
  logic        push_ok;
  logic        pop_ok;

  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Storage, pointers and occupancy.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; the two entries are reset so the stream outputs read 0
  // after reset instead of stale data.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop_ok) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == 2'd2);
  assign empty = (count == 2'd0);

endmodule

// File: rtl/solver_drain.sv
// Drains the per-solver result RAMs in (solver, address) order onto a
// valid/ready stream. Optional feature macro: SOLVER_DRAIN_CHECKSUM_EN adds a
// 16-bit running byte checksum of the transferred pixels.
module solver_drain
  import solver_drain_pkg::*;
#(
  parameter int NUM_SOLVERS = 1,
  parameter int DEPTH       = 1024
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  output logic [SOLVER_ID_W-1:0]    rd_solver_id,
  output logic [RAM_ADDR_W-1:0]     rd_addr,
  input  logic signed [PIXEL_W-1:0] rd_data_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [PIXEL_W-1:0] out_data,
  output logic [SOLVER_ID_W-1:0]    out_solver_id,
  output logic [RAM_ADDR_W-1:0]     out_addr,
  output logic                      busy,
  output logic                      done
`ifdef SOLVER_DRAIN_CHECKSUM_EN
  ,output logic [15:0]              checksum
`endif
);

  localparam logic [SOLVER_ID_W-1:0] LAST_SID  = SOLVER_ID_W'(NUM_SOLVERS - 1);
  localparam logic [RAM_ADDR_W-1:0]  LAST_ADDR = RAM_ADDR_W'(DEPTH - 1);

  drain_state_t           state;
  drain_state_t           state_next;
  logic                   inflight;
  logic [SOLVER_ID_W-1:0] tag_sid;
  logic [RAM_ADDR_W-1:0]  tag_addr;
  logic                   issue;
  logic                   last_issue;
  logic                   pop;
  logic                   accept_start;
  logic [2:0]             occupancy;
  logic [1:0]             fifo_count;
  logic                   fifo_full;
  logic                   fifo_empty;
  drain_word_t            push_word;
  drain_word_t            head_word;

  assign accept_start = (state == IDLE) && start;
  assign pop          = out_valid && out_ready;

  // A word leaving this cycle frees its slot for the read issued this cycle;
  // without that, a 2-entry FIFO could only sustain half rate.
  assign occupancy  = 3'(fifo_count) + 3'(inflight) - 3'(pop);
  assign issue      = (state == ISSUE) && !(fifo_full && !pop)
                      && (occupancy < 3'(CREDIT_LIMIT));
  assign last_issue = issue && (rd_solver_id == LAST_SID) && (rd_addr == LAST_ADDR);

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state and done pulse.
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    done       = 1'b0;
    case (state)
      IDLE:  if (start) state_next = ISSUE;
      ISSUE: if (last_issue) state_next = FLUSH;
      FLUSH: begin
        if (fifo_empty && !inflight) begin
          done       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // Issue pointer, which is also the registered RAM read address.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_solver_id <= '0;
      rd_addr      <= '0;
    end else if (accept_start) begin
      rd_solver_id <= '0;
      rd_addr      <= '0;
    end else if (issue && !last_issue) begin
      if (rd_addr == LAST_ADDR) begin
        rd_addr      <= '0;
        rd_solver_id <= rd_solver_id + SOLVER_ID_W'(1);
      end else begin
        rd_addr <= rd_addr + RAM_ADDR_W'(1);
      end
    end
  end

  // Tag delayed alongside the read so it lines up with rd_data_in.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      inflight <= 1'b0;
      tag_sid  <= '0;
      tag_addr <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        tag_sid  <= rd_solver_id;
        tag_addr <= rd_addr;
      end
    end
  end

  assign push_word = '{solver_id: tag_sid, addr: tag_addr, data: rd_data_in};

  drain_fifo2 u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (inflight),
    .pop   (pop),
    .wdata (push_word),
    .rdata (head_word),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign out_valid     = !fifo_empty;
  assign out_data      = head_word.data;
  assign out_solver_id = head_word.solver_id;
  assign out_addr      = head_word.addr;

`ifdef SOLVER_DRAIN_CHECKSUM_EN
  // Running sum of transferred bytes, restarted by each accepted start.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)             checksum <= 16'h0000;
    else if (accept_start) checksum <= 16'h0000;
    else if (pop)          checksum <= checksum + {8'h00, out_data};
  end
`endif

endmodule

// File: tb/tb_solver_drain.sv
// Randomised self-checking bench for solver_drain (2 banks x 4 words).
module tb_solver_drain;

  localparam int NS        = 2;
  localparam int DP        = 4;
  localparam int NUM_WORDS = NS * DP;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [5:0]  rd_solver_id;
  logic [9:0]  rd_addr;
  logic [7:0]  rd_data_in = 8'h00;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_data;
  logic [5:0]  out_solver_id;
  logic [9:0]  out_addr;
  logic        busy;
  logic        done;
`ifdef SOLVER_DRAIN_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  solver_drain #(.NUM_SOLVERS(NS), .DEPTH(DP)) dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .rd_solver_id  (rd_solver_id),
    .rd_addr       (rd_addr),
    .rd_data_in    (rd_data_in),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_solver_id (out_solver_id),
    .out_addr      (out_addr),
    .busy          (busy),
    .done          (done)
`ifdef SOLVER_DRAIN_CHECKSUM_EN
    ,.checksum     (checksum)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    int         sid;
    int         addr;
    logic [7:0] data;
  } word_t;

  logic [7:0] mem [NS][DP];
  word_t      exp_q[$];
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  bit         mon_en = 1'b0;
  int         start_cyc = 0;
  int         got_count = 0;
  int         done_count = 0;
  int         done_cyc = -1;
  int         busy_fall_cyc = -1;
  int         first_valid_cyc = -1;
  logic [15:0] exp_sum = 16'h0000;

  always @(posedge clock) cyc <= cyc + 1;

  // Result RAM: data appears one cycle after the address.
  always @(posedge clock) rd_data_in <= mem[int'(rd_solver_id) % NS][int'(rd_addr) % DP];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic ready_for(input int mode, input int i);
    case (mode)
      0:       return 1'b1;
      1:       return (i % 4 == 0) || (i % 4 == 3);
      2:       return i >= 20;
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  task automatic check_reset_outputs();
    check("rst_rd_sid",    32'(rd_solver_id),  0);
    check("rst_rd_addr",   32'(rd_addr),       0);
    check("rst_valid",     32'(out_valid),     0);
    check("rst_data",      32'(out_data),      0);
    check("rst_out_sid",   32'(out_solver_id), 0);
    check("rst_out_addr",  32'(out_addr),      0);
    check("rst_busy",      32'(busy),          0);
    check("rst_done",      32'(done),          0);
`ifdef SOLVER_DRAIN_CHECKSUM_EN
    check("rst_checksum",  32'(checksum),      0);
`endif
  endtask

  // Stream monitor and scoreboard, sampling on the falling edge.
  initial begin
    bit          prev_stall = 1'b0;
    logic [31:0] prev_word  = '0;
    word_t       w;
    forever begin
      @(negedge clock);
      if (!mon_en) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("hold_valid", 32'(out_valid), 1);
          check("hold_word", {8'h00, out_solver_id, out_addr, out_data}, prev_word);
        end
        prev_stall = out_valid && !out_ready;
        prev_word  = {8'h00, out_solver_id, out_addr, out_data};
        if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc - start_cyc;
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check("word_count", got_count + 1, NUM_WORDS);
          end else begin
            w = exp_q.pop_front();
            check("out_data", 32'(out_data),      32'(w.data));
            check("out_sid",  32'(out_solver_id), w.sid);
            check("out_addr", 32'(out_addr),      w.addr);
          end
          got_count++;
        end
        if (done) begin
          done_count++;
          done_cyc = cyc - start_cyc;
`ifdef SOLVER_DRAIN_CHECKSUM_EN
          check("checksum", 32'(checksum), 32'(exp_sum));
`endif
        end
        if (done_count > 0 && !busy && busy_fall_cyc < 0) busy_fall_cyc = cyc - start_cyc;
      end
    end
  end

  // fill: 0 random, 1 ramp (bank0 0..3, bank1 -1..-4), 2 all 8'hFF.
  // abort_after > 0 asserts reset once that many words have been taken.
  task automatic run_pass(input int mode, input bit extra_start,
                          input int abort_after, input int fill);
    int  i = 0;
    int  trail = 0;
    bit  finished = 1'b0;
    bit  aborted = 1'b0;
    exp_q.delete();
    exp_sum = 16'h0000;
    for (int s = 0; s < NS; s++) begin
      for (int a = 0; a < DP; a++) begin
        case (fill)
          1:       mem[s][a] = (s == 0) ? 8'(a) : 8'(-(a + 1));
          2:       mem[s][a] = 8'hFF;
          default: mem[s][a] = 8'($urandom);
        endcase
        exp_q.push_back('{sid: s, addr: a, data: mem[s][a]});
        exp_sum = exp_sum + {8'h00, mem[s][a]};
      end
    end
    got_count = 0; done_count = 0; done_cyc = -1;
    busy_fall_cyc = -1; first_valid_cyc = -1;
    out_ready = ready_for(mode, 0);
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    start_cyc = cyc;
    mon_en = 1'b1;
    while (!finished && !aborted && i < 400) begin
      out_ready = ready_for(mode, i);
      start = extra_start && (i == 3 || i == NUM_WORDS + 2);
      if (mode == 2 && (i == 5 || i == 19)) begin
        check("stall_reads", 32'(rd_solver_id == 0 && rd_addr <= 2), 1);
        check("stall_valid", 32'(out_valid), 1);
        check("stall_word0", 32'(out_data), 32'(mem[0][0]));
        check("stall_tag", {16'h0, out_solver_id, out_addr}, 0);
      end
      if (abort_after > 0 && got_count >= abort_after) begin
        mon_en = 1'b0;
        #2 reset = 1'b1;
        #1 check_reset_outputs();
        @(posedge clock); #1;
        reset = 1'b0;
        aborted = 1'b1;
      end else begin
        if (done_count > 0) trail++;
        finished = (trail > 4);
        @(posedge clock); #1;
        i++;
      end
    end
    start = 1'b0;
    mon_en = 1'b0;
    if (!aborted) begin
      if (!finished) check("pass_timeout", done_count, 1);
      check("words",       got_count,    NUM_WORDS);
      check("remaining",   exp_q.size(), 0);
      check("done_pulses", done_count,   1);
      check("busy_idle",   32'(busy),    0);
      if (mode == 0) begin
        check("first_valid",  first_valid_cyc, 2);
        check("done_latency", done_cyc,        NUM_WORDS + 2);
        check("busy_fall",    busy_fall_cyc,   NUM_WORDS + 3);
      end
    end
    repeat (2) @(posedge clock);
    #1;
  endtask

  initial begin
    for (int s = 0; s < NS; s++)
      for (int a = 0; a < DP; a++) mem[s][a] = 8'h00;
    repeat (2) @(posedge clock);
    #1 check_reset_outputs();
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    run_pass(0, 1'b0, 0, 1);   // ramp data, free-running stream
    run_pass(1, 1'b0, 0, 1);   // ready 1,0,0,1 pattern
    run_pass(2, 1'b0, 0, 0);   // 20-cycle stall after start
    run_pass(0, 1'b1, 0, 0);   // start pulses while busy, incl. the done cycle
    run_pass(3, 1'b0, 0, 0);   // random backpressure
    run_pass(3, 1'b0, 0, 2);   // all 8'hFF
    run_pass(0, 1'b0, 3, 0);   // reset after 3 words
    run_pass(0, 1'b0, 0, 0);   // replay from (0,0)
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
